alu_uart_sequencer: RTL and testbench

Frame-level controller between the UART receiver, the ALU and the UART transmitter. It collects a 3-byte binary command frame (operand A, operand B, opcode) from the rx side and drives the ALU operand and opcode inputs. It captures the ALU result and sends it back as two uppercase ASCII hex characters followed by a line feed, using the tx start/done handshake. It also handles inter-byte timeout resync and rx overrun during transmission.

---
 rtl/alu_uart_sequencer_pkg.sv | 31 +++
 rtl/alu_uart_sequencer_nibble_to_ascii.sv | 18 +
 rtl/alu_uart_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART frame sequencer and the ALU it drives:
// the FSM state encoding, the ASCII characters used in replies, and the ALU opcodes.
package alu_uart_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_GET_A,
      ST_GET_B,
      ST_GET_OP,
      ST_EXEC,
      ST_SEND_HI,
      ST_WAIT_HI,
      ST_SEND_LO,
      ST_WAIT_LO,
      ST_SEND_NL,
      ST_WAIT_NL
   } seq_state_t;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_sequencer_nibble_to_ascii.sv
// Converts one 4-bit value into its uppercase ASCII hex character.
module nibble_to_ascii
   import alu_uart_sequencer_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // Digits map onto '0'..'9', values 10..15 onto 'A'..'F'.
   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_0 + {4'h0, nibble};
      end else begin
         ascii = ASCII_A + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: collects operand A, operand B and opcode bytes from the UART
// receiver, drives the ALU, and replies with the result as two hex characters
// plus a line feed through the transmitter start/done handshake.
module alu_uart_sequencer
   import alu_uart_sequencer_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 1_000_000,
   parameter int DBIT          = 8
)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [DBIT-1:0] rx_data,
   output logic [DBIT-1:0] alu_a,
   output logic [DBIT-1:0] alu_b,
   output logic [5:0]      alu_op,
   input  logic [DBIT-1:0] alu_result,
   output logic            tx_start,
   output logic [7:0]      tx_data,
   input  logic            tx_done_tick,
   output logic            busy,
   output logic            overrun,
   output logic            timeout
);

   localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_TICKS - 1);

   seq_state_t      state, state_next;
   logic [DBIT-1:0] a_next, b_next, result_reg, result_next;
   logic [5:0]      op_next;
   logic [CW-1:0]   count, count_next;
   logic            overrun_next;
   logic            transmitting;
   logic [3:0]      nibble_sel;
   logic [7:0]      nibble_ascii;

   // State, operand, result, inter-byte counter and sticky overrun registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_GET_A;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         result_reg <= '0;
         count      <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         alu_a      <= a_next;
         alu_b      <= b_next;
         alu_op     <= op_next;
         result_reg <= result_next;
         count      <= count_next;
         overrun    <= overrun_next;
      end
   end

   // Next-state logic: byte collection with inter-byte timeout, then the
   // three-character reply, each character sent once and then awaited.
   always_comb begin
      state_next   = state;
      a_next       = alu_a;
      b_next       = alu_b;
      op_next      = alu_op;
      result_next  = result_reg;
      count_next   = '0;
      overrun_next = overrun;
      tx_start     = 1'b0;
      timeout      = 1'b0;
      case (state)
         ST_GET_A: begin
            if (rx_done_tick) begin
               a_next     = rx_data;
               state_next = ST_GET_B;
            end
         end
         ST_GET_B: begin
            if (rx_done_tick) begin
               b_next     = rx_data;
               state_next = ST_GET_OP;
            end else if (count == LAST_COUNT) begin
               timeout    = 1'b1;
               state_next = ST_GET_A;
            end else begin
               count_next = count + CW'(1);
            end
         end
         ST_GET_OP: begin
            if (rx_done_tick) begin
               op_next    = rx_data[5:0];
               state_next = ST_EXEC;
            end else if (count == LAST_COUNT) begin
               timeout    = 1'b1;
               state_next = ST_GET_A;
            end else begin
               count_next = count + CW'(1);
            end
         end
         ST_EXEC: begin
            result_next = alu_result;
            state_next  = ST_SEND_HI;
         end
         ST_SEND_HI: begin
            tx_start   = 1'b1;
            state_next = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (tx_done_tick) state_next = ST_SEND_LO;
         end
         ST_SEND_LO: begin
            tx_start   = 1'b1;
            state_next = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (tx_done_tick) state_next = ST_SEND_NL;
         end
         ST_SEND_NL: begin
            tx_start   = 1'b1;
            state_next = ST_WAIT_NL;
         end
         ST_WAIT_NL: begin
            if (tx_done_tick) state_next = ST_GET_A;
         end
         default: begin
            state_next = ST_GET_A;
         end
      endcase
      if (rx_done_tick && transmitting) begin
         overrun_next = 1'b1;
      end
   end

   assign busy         = (state != ST_GET_A);
   assign transmitting = (state != ST_GET_A) && (state != ST_GET_B) && (state != ST_GET_OP);
   assign nibble_sel   = ((state == ST_SEND_HI) || (state == ST_WAIT_HI)) ? result_reg[7:4]
                                                                          : result_reg[3:0];

   nibble_to_ascii u_nibble_to_ascii (
      .nibble (nibble_sel),
      .ascii  (nibble_ascii)
   );

   // The outgoing character follows the reply state so it stays put from
   // tx_start until the transmitter reports done; idle states present zero.
   always_comb begin
      tx_data = 8'h00;
      case (state)
         ST_SEND_HI, ST_WAIT_HI, ST_SEND_LO, ST_WAIT_LO: tx_data = nibble_ascii;
         ST_SEND_NL, ST_WAIT_NL:                         tx_data = ASCII_LF;
         default:                                        tx_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer: a table of command frames with
// hand-computed hex replies, plus hand-written timeout, overrun, reset and
// ignored-handshake sequences.
module tb_alu_uart_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic [7:0] alu_a, alu_b, alu_result, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, tx_done_tick, busy, overrun, timeout;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op_byte;
      logic [5:0] exp_op;
      logic [7:0] exp_hi;
      logic [7:0] exp_lo;
   } frame_vec_t;

   frame_vec_t vecs[11];

   alu_uart_sequencer #(.TIMEOUT_TICKS(16), .DBIT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .overrun      (overrun),
      .timeout      (timeout)
   );

   // 10 ns system clock.
   always #5 clk = ~clk;

   // Reference ALU the sequencer drives.
   always_comb begin
      case (alu_op)
         6'b100000: alu_result = alu_a + alu_b;
         6'b100010: alu_result = alu_a - alu_b;
         6'b100100: alu_result = alu_a & alu_b;
         6'b100101: alu_result = alu_a | alu_b;
         6'b100110: alu_result = alu_a ^ alu_b;
         6'b000011: alu_result = 8'($signed(alu_a) >>> alu_b);
         6'b000010: alu_result = alu_a >> alu_b;
         6'b100111: alu_result = ~(alu_a | alu_b);
         default:   alu_result = 8'h00;
      endcase
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   task automatic sendByte(input logic [7:0] value);
      @(negedge clk);
      rx_data      = value;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
      #1;
   endtask

   task automatic waitTxStart(input string name);
      int n = 0;
      while (!tx_start && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput({name, " tx_start seen"}, {7'd0, tx_start}, 8'h01);
   endtask

   task automatic collectByte(input logic [7:0] exp, input string name,
                              input bit early_done, input bit inject_rx);
      waitTxStart(name);
      checkOutput({name, " tx_data"}, tx_data, exp);
      if (early_done) tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (inject_rx) begin
         rx_data      = 8'h99;
         rx_done_tick = 1'b1;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput({name, " held"}, tx_data, exp);
         checkOutput({name, " no restart"}, {7'd0, tx_start}, 8'h00);
         @(negedge clk);
         rx_done_tick = 1'b0;
         #1;
      end
      if (inject_rx) checkOutput({name, " overrun set"}, {7'd0, overrun}, 8'h01);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
   endtask

   task automatic applyStimulus(input int idx, input bit early_done_hi, input bit inject_lo);
      frame_vec_t v = vecs[idx];
      string tag = $sformatf("vec%0d", idx);
      sendByte(v.a);
      sendByte(v.b);
      @(negedge clk);
      rx_data      = v.op_byte;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
      #1;
      checkOutput({tag, " tx_start in EXEC"}, {7'd0, tx_start}, 8'h00);
      checkOutput({tag, " alu_a"}, alu_a, v.a);
      checkOutput({tag, " alu_b"}, alu_b, v.b);
      checkOutput({tag, " alu_op"}, {2'b00, alu_op}, {2'b00, v.exp_op});
      @(negedge clk);
      #1;
      checkOutput({tag, " tx_start latency"}, {7'd0, tx_start}, 8'h01);
      collectByte(v.exp_hi, {tag, " hi"}, early_done_hi, 1'b0);
      collectByte(v.exp_lo, {tag, " lo"}, 1'b0, inject_lo);
      collectByte(8'h0A, {tag, " nl"}, 1'b0, 1'b0);
      checkOutput({tag, " busy after frame"}, {7'd0, busy}, 8'h00);
      checkOutput({tag, " idle tx_start"}, {7'd0, tx_start}, 8'h00);
   endtask

   task automatic checkResetState(input string name);
      checkOutput({name, " alu_a"}, alu_a, 8'h00);
      checkOutput({name, " alu_b"}, alu_b, 8'h00);
      checkOutput({name, " alu_op"}, {2'b00, alu_op}, 8'h00);
      checkOutput({name, " tx_data"}, tx_data, 8'h00);
      checkOutput({name, " tx_start"}, {7'd0, tx_start}, 8'h00);
      checkOutput({name, " busy"}, {7'd0, busy}, 8'h00);
      checkOutput({name, " overrun"}, {7'd0, overrun}, 8'h00);
      checkOutput({name, " timeout"}, {7'd0, timeout}, 8'h00);
   endtask

   initial begin
      //            a      b      op byte exp_op  hi     lo
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h30, 8'h38};  // ADD  -> 08
      vecs[1]  = '{8'h03, 8'h05, 8'h22, 6'h22, 8'h46, 8'h45};  // SUB  -> FE
      vecs[2]  = '{8'h0F, 8'h01, 8'h24, 6'h24, 8'h30, 8'h31};  // AND  -> 01
      vecs[3]  = '{8'hA5, 8'h5A, 8'h26, 6'h26, 8'h46, 8'h46};  // XOR  -> FF
      vecs[4]  = '{8'h0C, 8'h0A, 8'h25, 6'h25, 8'h30, 8'h45};  // OR   -> 0E
      vecs[5]  = '{8'h80, 8'h02, 8'h03, 6'h03, 8'h45, 8'h30};  // SRA  -> E0
      vecs[6]  = '{8'h80, 8'h02, 8'h02, 6'h02, 8'h32, 8'h30};  // SRL  -> 20
      vecs[7]  = '{8'h0F, 8'hF0, 8'h27, 6'h27, 8'h30, 8'h30};  // NOR  -> 00
      vecs[8]  = '{8'h9A, 8'h26, 8'hE0, 6'h20, 8'h43, 8'h30};  // ADD, top bits ignored -> C0
      vecs[9]  = '{8'h11, 8'h22, 8'h20, 6'h20, 8'h33, 8'h33};  // ADD  -> 33
      vecs[10] = '{8'h7B, 8'h01, 8'h20, 6'h20, 8'h37, 8'h43};  // ADD  -> 7C

      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkResetState("reset");

      // Basic frames.
      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);

      // Partial frame abandoned after 16 idle cycles.
      $display("[TB] timeout sequence");
      sendByte(8'h07);
      for (int i = 1; i <= 16; i++) begin
         checkOutput($sformatf("timeout cycle %0d", i), {7'd0, timeout}, (i == 16) ? 8'h01 : 8'h00);
         @(negedge clk);
         #1;
      end
      checkOutput("timeout busy after", {7'd0, busy}, 8'h00);
      checkOutput("timeout pulse ends", {7'd0, timeout}, 8'h00);
      applyStimulus(2, 1'b0, 1'b0);

      for (int i = 3; i <= 8; i++) applyStimulus(i, 1'b0, 1'b0);
      checkOutput("overrun clear before", {7'd0, overrun}, 8'h00);

      // Byte arriving while the low character is in flight.
      $display("[TB] overrun sequence");
      applyStimulus(1, 1'b0, 1'b1);
      checkOutput("overrun sticky", {7'd0, overrun}, 8'h01);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput("overrun sticky later", {7'd0, overrun}, 8'h01);

      // tx_done_tick while idle and during SEND_HI must be ignored.
      $display("[TB] ignored handshake sequence");
      @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
      checkOutput("idle done busy", {7'd0, busy}, 8'h00);
      checkOutput("idle done tx_start", {7'd0, tx_start}, 8'h00);
      applyStimulus(4, 1'b1, 1'b0);

      // Byte arriving exactly in the expiry cycle is accepted.
      $display("[TB] expiry-cycle byte sequence");
      sendByte(8'h11);
      repeat (15) @(negedge clk);
      rx_data      = 8'h22;
      rx_done_tick = 1'b1;
      #1;
      checkOutput("expiry no timeout", {7'd0, timeout}, 8'h00);
      @(negedge clk);
      rx_done_tick = 1'b0;
      #1;
      checkOutput("expiry byte accepted", alu_b, 8'h22);
      checkOutput("expiry still busy", {7'd0, busy}, 8'h01);
      sendByte(8'h20);
      collectByte(8'h33, "expiry hi", 1'b0, 1'b0);
      collectByte(8'h33, "expiry lo", 1'b0, 1'b0);
      collectByte(8'h0A, "expiry nl", 1'b0, 1'b0);
      checkOutput("expiry frame done", {7'd0, busy}, 8'h00);

      // Reset while waiting for the high character to finish.
      $display("[TB] reset mid-transmission sequence");
      sendByte(8'h05);
      sendByte(8'h03);
      sendByte(8'h20);
      waitTxStart("pre-reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkResetState("mid reset");
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("post reset tx_start", {7'd0, tx_start}, 8'h00);
         checkOutput("post reset busy", {7'd0, busy}, 8'h00);
         @(negedge clk);
         #1;
      end
      applyStimulus(10, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
